hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Pipeline hazard and forwarding unit for the 5-stage MIPS core.
- Consumes the staged control bits that the pipeline controller produces (regwrite/memtoreg per stage, branch/bne/jr in D, mult/div start in E), plus register numbers from the datapath.
- Returns stall, flush and forwarding selects to the controller and datapath, closing the control loop; flushE feeds the controller's E-stage register clear.
- Owns a sequential mult/div busy counter that interlocks HI/LO reads and back-to-back mult/div against the iterative multiplier/divider.

Parameters:
MULT_CYCLES, 4, cycles the HI/LO unit needs for mult/multu (>=1)
DIV_CYCLES, 32, cycles the HI/LO unit needs for div/divu (>=1, >=MULT_CYCLES)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
rsD, rtD  in  5 each  source registers in Decode
rsE, rtE  in  5 each  source registers in Execute
writeregE, writeregM, writeregW  in  5 each  destination register per stage
regwriteE, regwriteM, regwriteW  in  1 each  register-file write enable per stage
memtoregE, memtoregM  in  1 each  load in stage
branchD, bneD, jrD  in  1 each  beq / bne / jr in Decode
mfhlD  in  2  nonzero = mfhi/mflo in Decode
mdD  in  1  mult/div instruction in Decode
mdstartE  in  1  mult/div in Execute, starts HI/LO unit this cycle
mddivE  in  1  1 = divide, 0 = multiply (valid with mdstartE)
stallF, stallD  out  1 each  hold PC / IF-ID register
flushE  out  1  clear ID-EX register (bubble)
forwardaD, forwardbD  out  1 each  branch-compare operand from ALUOutM
forwardaE, forwardbE  out  2 each  ALU operand select: 00 regfile, 01 ResultW, 10 ALUOutM
mdbusy  out  1  HI/LO unit busy
mddone  out  1  one-cycle pulse, last busy cycle

Behaviour:
- Register $0 is never forwarded from and never causes a stall; every match term requires the source != 0.
- forwardaE: 10 if rsE==writeregM & regwriteM; else 01 if rsE==writeregW & regwriteW; else 00. M has priority over W. forwardbE is the same using rtE.
- forwardaD = rsD==writeregM & regwriteM. forwardbD is the same using rtD.
- lwstall = memtoregE & rtE!=0 & (rtE==rsD | rtE==rtD).
- branchstall = (branchD|bneD|jrD) & ((regwriteE & writeregE matches a D source) | (memtoregM & writeregM matches a D source)).
  - D sources are rsD and rtD; for jrD only rsD counts.
- Mult/div counter: count register, width clog2(DIV_CYCLES+1); mdbusy = (count!=0).
  - mdstartE & !mdbusy: load count = DIV_CYCLES if mddivE, else MULT_CYCLES.
  - Otherwise, if count!=0, decrement by 1.
  - A start in cycle t gives mdbusy high for cycles t+1 .. t+L.
  - mddone = (count==1).
  - mdstartE while mdbusy is a protocol violation: ignore it, counter unaffected; the bench flags it with an assertion.
- mdstall = (mfhlD!=0 | mdD) & (mdbusy | mdstartE).
- stallF = stallD = flushE = lwstall | branchstall | mdstall. All outputs except count are combinational.
- Reset (asynchronous, any time, including mid-operation): count=0, so mdbusy=0 and mddone=0. Stall/forward outputs then follow the inputs combinationally.
- Simultaneous hazards: the stall outputs OR together; there are no priorities between them. Forwarding is independent of the stall outputs.

Test Plan:
- Forward E: rsE=5, writeregM=5, regwriteM=1, writeregW=5, regwriteW=1 -> forwardaE=10. Then drop regwriteM -> 01. Then rsE=0 with all writeregs=0 -> 00.
- Load-use: memtoregE=1, rtE=8, rsD=8 -> stallF=stallD=flushE=1. With rtE=0 -> all 0.
- Branch: branchD=1, rsD=3, regwriteE=1, writeregE=3 -> stall. Same with jrD=1, rtD=3, rsD=4 -> no stall. memtoregM=1, writeregM=4, rsD=4 -> stall. regwriteM=1 only, writeregM=4 -> forwardaD=1, no stall.
- Mult: mdstartE=1, mddivE=0 at cycle t -> mdbusy=1 for t+1..t+4, mddone=1 at t+4 only. mfhlD=10 held from t -> stall through t+4, released at t+5.
- Div: mddivE=1 -> mdbusy for exactly 32 cycles. mdD=1 in that window -> stall until mdbusy falls.
- Reset at cycle 10 of a divide -> mdbusy and mddone fall immediately (asynchronously) and the pending mfhlD stall clears the same cycle.

Source files
------------

// File: rtl/hazard_if.sv
// Hazard unit bundle: pipeline control bits and register numbers in,
// stall, flush and forwarding selects out.
interface hazard_if;
    logic [4:0] rsD, rtD, rsE, rtE;
    logic [4:0] writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW;
    logic       memtoregE, memtoregM;
    logic       branchD, bneD, jrD;
    logic [1:0] mfhlD;
    logic       mdD, mdstartE, mddivE;
    logic       stallF, stallD, flushE;
    logic       forwardaD, forwardbD;
    logic [1:0] forwardaE, forwardbE;
    logic       mdbusy, mddone;

    modport master (
        output rsD, rtD, rsE, rtE,
        output writeregE, writeregM, writeregW,
        output regwriteE, regwriteM, regwriteW,
        output memtoregE, memtoregM,
        output branchD, bneD, jrD,
        output mfhlD, mdD, mdstartE, mddivE,
        input  stallF, stallD, flushE,
        input  forwardaD, forwardbD,
        input  forwardaE, forwardbE,
        input  mdbusy, mddone
    );

    modport slave (
        input  rsD, rtD, rsE, rtE,
        input  writeregE, writeregM, writeregW,
        input  regwriteE, regwriteM, regwriteW,
        input  memtoregE, memtoregM,
        input  branchD, bneD, jrD,
        input  mfhlD, mdD, mdstartE, mddivE,
        output stallF, stallD, flushE,
        output forwardaD, forwardbD,
        output forwardaE, forwardbE,
        output mdbusy, mddone
    );
endinterface

// File: rtl/hazard_unit.sv
// Hazard detection, operand forwarding and HI/LO busy interlock
// for the 5-stage MIPS pipeline.
module hazard_unit #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic     clk,
    input  logic     reset,
    hazard_if.slave  hif
);
    localparam int CW = $clog2(DIV_CYCLES + 1);

    logic [CW-1:0] count_q, count_d;
    logic          busy;
    logic          lwstall, branchstall, mdstall;
    logic          bhitE, bhitM, rt_used;

    // $0 is hardwired zero, so it never matches a producer
    function automatic logic hit(input logic [4:0] src,
                                 input logic [4:0] dst,
                                 input logic       we);
        return we && (src != 5'd0) && (src == dst);
    endfunction

    assign hif.forwardaE =
        hit(hif.rsE, hif.writeregM, hif.regwriteM) ? 2'b10 :
        hit(hif.rsE, hif.writeregW, hif.regwriteW) ? 2'b01 :
                                                     2'b00;
    assign hif.forwardbE =
        hit(hif.rtE, hif.writeregM, hif.regwriteM) ? 2'b10 :
        hit(hif.rtE, hif.writeregW, hif.regwriteW) ? 2'b01 :
                                                     2'b00;

    assign hif.forwardaD = hit(hif.rsD, hif.writeregM, hif.regwriteM);
    assign hif.forwardbD = hit(hif.rtD, hif.writeregM, hif.regwriteM);

    assign lwstall = hif.memtoregE && (hif.rtE != 5'd0) &&
                     ((hif.rtE == hif.rsD) || (hif.rtE == hif.rtD));

    // jr reads only rs; rt matters for the compare branches
    assign rt_used = hif.branchD || hif.bneD;

    assign bhitE =
        hit(hif.rsD, hif.writeregE, hif.regwriteE) ||
        (rt_used && hit(hif.rtD, hif.writeregE, hif.regwriteE));
    assign bhitM =
        hit(hif.rsD, hif.writeregM, hif.memtoregM) ||
        (rt_used && hit(hif.rtD, hif.writeregM, hif.memtoregM));

    assign branchstall = (hif.branchD || hif.bneD || hif.jrD) &&
                         (bhitE || bhitM);

    assign busy = (count_q != '0);

    assign mdstall = ((hif.mfhlD != 2'b00) || hif.mdD) &&
                     (busy || hif.mdstartE);

    assign hif.stallF = lwstall || branchstall || mdstall;
    assign hif.stallD = hif.stallF;
    assign hif.flushE = hif.stallF;

    assign hif.mdbusy = busy;
    assign hif.mddone = (count_q == CW'(1));

    // A start while busy is dropped; the running operation keeps counting
    always_comb begin
        count_d = count_q;
        if (hif.mdstartE && !busy)
            count_d = hif.mddivE ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        else if (busy)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end
endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed cases plus random
// stimulus against a cycle-indexed reference model.
module tb_hazard_unit;
    localparam int MC = 4;
    localparam int DC = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_if hif ();

    hazard_unit #(
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .hif  (hif)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    // HI/LO unit busy for cycles up to and including busy_end
    int busy_end = -1;

    always @(posedge clk)
        if (!reset)
            assert (!(hif.mdstartE && hif.mdbusy))
                else $error("mdstartE asserted while mdbusy");

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic clr();
        hif.rsD = 0; hif.rtD = 0; hif.rsE = 0; hif.rtE = 0;
        hif.writeregE = 0; hif.writeregM = 0; hif.writeregW = 0;
        hif.regwriteE = 0; hif.regwriteM = 0; hif.regwriteW = 0;
        hif.memtoregE = 0; hif.memtoregM = 0;
        hif.branchD = 0; hif.bneD = 0; hif.jrD = 0;
        hif.mfhlD = 0; hif.mdD = 0; hif.mdstartE = 0; hif.mddivE = 0;
    endtask

    function automatic bit same(input int a, input int b);
        return (a != 0) && (a == b);
    endfunction

    function automatic int fwd_e(input int src);
        if (hif.regwriteM && same(src, hif.writeregM)) return 2;
        if (hif.regwriteW && same(src, hif.writeregW)) return 1;
        return 0;
    endfunction

    task automatic verify(input string tag);
        bit bz, dn, lw, br, md, uses_rt, st;
        int srcs[$];
        bz = (cyc <= busy_end);
        dn = (cyc == busy_end);
        lw = hif.memtoregE &&
             (same(hif.rtE, hif.rsD) || same(hif.rtE, hif.rtD));
        uses_rt = hif.branchD || hif.bneD;
        srcs = {int'(hif.rsD)};
        if (uses_rt) srcs.push_back(int'(hif.rtD));
        br = 0;
        if (hif.branchD || hif.bneD || hif.jrD)
            foreach (srcs[i]) begin
                if (hif.regwriteE && same(srcs[i], hif.writeregE)) br = 1;
                if (hif.memtoregM && same(srcs[i], hif.writeregM)) br = 1;
            end
        md = ((hif.mfhlD != 0) || hif.mdD) && (bz || hif.mdstartE);
        st = lw || br || md;
        chk({tag, "/faE"}, 32'(hif.forwardaE), 32'(fwd_e(hif.rsE)));
        chk({tag, "/fbE"}, 32'(hif.forwardbE), 32'(fwd_e(hif.rtE)));
        chk({tag, "/faD"}, 32'(hif.forwardaD),
            32'(hif.regwriteM && same(hif.rsD, hif.writeregM)));
        chk({tag, "/fbD"}, 32'(hif.forwardbD),
            32'(hif.regwriteM && same(hif.rtD, hif.writeregM)));
        chk({tag, "/stF"}, 32'(hif.stallF), 32'(st));
        chk({tag, "/stD"}, 32'(hif.stallD), 32'(st));
        chk({tag, "/flE"}, 32'(hif.flushE), 32'(st));
        chk({tag, "/busy"}, 32'(hif.mdbusy), 32'(bz));
        chk({tag, "/done"}, 32'(hif.mddone), 32'(dn));
        if (!reset && hif.mdstartE && !bz)
            busy_end = cyc + (hif.mddivE ? DC : MC);
    endtask

    initial begin
        int nb;
        reset = 1'b1;
        clr();
        repeat (2) @(posedge clk);
        #4;
        chk("rst_busy", 32'(hif.mdbusy), 0);
        chk("rst_done", 32'(hif.mddone), 0);
        verify("rst");
        next();
        reset = 1'b0;

        next(); clr();
        hif.rsE = 5; hif.writeregM = 5; hif.regwriteM = 1;
        hif.writeregW = 5; hif.regwriteW = 1;
        #3 verify("fwdM"); chk("fwdM", 32'(hif.forwardaE), 2);
        next(); hif.regwriteM = 0;
        #3 verify("fwdW"); chk("fwdW", 32'(hif.forwardaE), 1);
        next(); clr(); hif.regwriteM = 1; hif.regwriteW = 1;
        #3 verify("fwd0"); chk("fwd0", 32'(hif.forwardaE), 0);

        next(); clr();
        hif.memtoregE = 1; hif.rtE = 8; hif.rsD = 8;
        #3 verify("lw");
        chk("lw_stF", 32'(hif.stallF), 1);
        chk("lw_flE", 32'(hif.flushE), 1);
        next(); hif.rtE = 0;
        #3 verify("lw0"); chk("lw0_stF", 32'(hif.stallF), 0);

        next(); clr();
        hif.branchD = 1; hif.rsD = 3; hif.regwriteE = 1; hif.writeregE = 3;
        #3 verify("brE"); chk("brE", 32'(hif.stallF), 1);
        next(); clr();
        hif.jrD = 1; hif.rtD = 3; hif.rsD = 4;
        hif.regwriteE = 1; hif.writeregE = 3;
        #3 verify("jr"); chk("jr", 32'(hif.stallF), 0);
        next(); clr();
        hif.branchD = 1; hif.memtoregM = 1; hif.writeregM = 4; hif.rsD = 4;
        #3 verify("brM"); chk("brM", 32'(hif.stallF), 1);
        next(); clr();
        hif.branchD = 1; hif.regwriteM = 1; hif.writeregM = 4; hif.rsD = 4;
        #3 verify("brF");
        chk("brF_fa", 32'(hif.forwardaD), 1);
        chk("brF_st", 32'(hif.stallF), 0);

        next(); clr();
        hif.mdstartE = 1; hif.mfhlD = 2'b10;
        #3 verify("mul0"); chk("mul0_st", 32'(hif.stallF), 1);
        for (int k = 1; k <= 5; k++) begin
            next(); hif.mdstartE = 0;
            #3 verify("mul");
            chk("mul_busy", 32'(hif.mdbusy), 32'(k <= MC));
            chk("mul_done", 32'(hif.mddone), 32'(k == MC));
            chk("mul_st", 32'(hif.stallF), 32'(k <= MC));
        end

        next(); clr();
        hif.mdstartE = 1; hif.mddivE = 1;
        #3 verify("div0");
        nb = 0;
        for (int k = 1; k <= DC + 4; k++) begin
            next(); hif.mdstartE = 0; hif.mdD = 1;
            #3 verify("div");
            if (hif.mdbusy) nb++;
        end
        chk("div_len", 32'(nb), DC);

        next(); clr();
        hif.mdstartE = 1; hif.mddivE = 1;
        #3 verify("rdiv0");
        for (int k = 1; k < 10; k++) begin
            next(); hif.mdstartE = 0; hif.mfhlD = 2'b01;
            #3 verify("rdiv");
        end
        next();
        #1 chk("rdiv_st", 32'(hif.stallF), 1);
        reset = 1'b1;
        busy_end = cyc - 1;
        #1;
        chk("rdiv_busy", 32'(hif.mdbusy), 0);
        chk("rdiv_done", 32'(hif.mddone), 0);
        chk("rdiv_stF", 32'(hif.stallF), 0);
        verify("rdiv_rst");
        next(); reset = 1'b0;
        #3 verify("rdiv_post");

        for (int k = 0; k < 800; k++) begin
            next();
            hif.rsD = 5'($urandom_range(0, 7));
            hif.rtD = 5'($urandom_range(0, 7));
            hif.rsE = 5'($urandom_range(0, 7));
            hif.rtE = 5'($urandom_range(0, 7));
            hif.writeregE = 5'($urandom_range(0, 7));
            hif.writeregM = 5'($urandom_range(0, 7));
            hif.writeregW = 5'($urandom_range(0, 7));
            hif.regwriteE = 1'($urandom);
            hif.regwriteM = 1'($urandom);
            hif.regwriteW = 1'($urandom);
            hif.memtoregE = 1'($urandom_range(0, 3) == 0);
            hif.memtoregM = 1'($urandom_range(0, 3) == 0);
            hif.branchD = 1'($urandom_range(0, 3) == 0);
            hif.bneD = 1'($urandom_range(0, 3) == 0);
            hif.jrD = 1'($urandom_range(0, 3) == 0);
            hif.mfhlD = ($urandom_range(0, 3) == 0) ?
                        2'($urandom_range(1, 2)) : 2'b00;
            hif.mdD = 1'($urandom_range(0, 5) == 0);
            hif.mddivE = 1'($urandom_range(0, 3) == 0);
            hif.mdstartE = (cyc > busy_end) &&
                           ($urandom_range(0, 7) == 0);
            #3 verify("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
